// File: rtl/dec_tree_pkg.sv
// Shared definitions for the decoder-tree evaluator sweep controller.
package dec_tree_pkg;

  localparam int unsigned N_VEC  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned FAIL_W = 5;

  // Reference sum-of-minterms function: minterms 4,5,11,12,13,14,15
  localparam logic [N_VEC-1:0] SOM_MASK = 16'hF830;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/dec_tree_sweep_score.sv
// Scoreboard for one sweep: captures F per vector, counts mismatches and
// remembers the lowest mismatching vector.
module dec_tree_sweep_score
  import dec_tree_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [IDX_W-1:0]  idx,
  input  logic              eval_f,
  input  logic              mask_bit,
  output logic              mismatch_c,
  output logic              clean_c,
  output logic [N_VEC-1:0]  truth_table,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [IDX_W-1:0]  first_fail
);

  // clean_c anticipates the post-sample count so pass can land with done
  assign mismatch_c = sample && (eval_f != mask_bit);
  assign clean_c    = (fail_cnt == '0) && !mismatch_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_table <= '0;
      fail_cnt    <= '0;
      first_fail  <= '0;
    end else if (clear) begin
      truth_table <= '0;
      fail_cnt    <= '0;
      first_fail  <= '0;
    end else if (sample) begin
      truth_table[idx] <= eval_f;
      if (mismatch_c) begin
        fail_cnt <= fail_cnt + FAIL_W'(1);
        if (fail_cnt == '0) first_fail <= idx;
      end
    end
  end

endmodule

// File: rtl/dec_tree_sweep_ctrl.sv
// Sweeps ABCD through all 16 vectors of the decoder-tree evaluator, samples F
// after a settle window and compares the captured truth table with a mask.
module dec_tree_sweep_ctrl
  import dec_tree_pkg::*;
#(
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_VEC-1:0]  expected_mask,
  input  logic              eval_f,
  output logic              eval_en,
  output logic [IDX_W-1:0]  eval_abcd,
  output logic              busy,
  output logic              done,
  output logic [N_VEC-1:0]  truth_table,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [IDX_W-1:0]  first_fail
);

  localparam int unsigned SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [SET_W-1:0]   cnt;
  logic [N_VEC-1:0]   mask_q;
  logic               accept;
  logic               sample;
  logic               mismatch_c;
  logic               clean_c;
  logic               last_vec;

  assign accept    = (state == ST_IDLE) && start;
  assign sample    = (state == ST_SAMPLE);
  assign last_vec  = (idx == IDX_W'(N_VEC - 1));
  // idx is a flop and is forced to 0 outside a sweep, so it doubles as the output
  assign eval_abcd = idx;

  dec_tree_sweep_score u_score (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (accept),
    .sample      (sample),
    .idx         (idx),
    .eval_f      (eval_f),
    .mask_bit    (mask_q[idx]),
    .mismatch_c  (mismatch_c),
    .clean_c     (clean_c),
    .truth_table (truth_table),
    .fail_cnt    (fail_cnt),
    .first_fail  (first_fail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      mask_q  <= '0;
      eval_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q  <= expected_mask;
            pass    <= 1'b0;
            idx     <= '0;
            cnt     <= SET_W'(SETTLE);
            eval_en <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - SET_W'(1);
          if (cnt <= SET_W'(1)) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (last_vec || (STOP_ON_FAIL && mismatch_c)) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            eval_en <= 1'b0;
            idx     <= '0;
            pass    <= clean_c;
            state   <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            cnt   <= SET_W'(SETTLE);
            state <= ST_WAIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_tree_sweep_ctrl.sv
// Directed bench for dec_tree_sweep_ctrl: three instances cover the default,
// stop-on-fail and long-settle configurations against a behavioural evaluator.
module tb_dec_tree_sweep_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        start_s;
  logic [15:0]       mask_s;
  logic              f0, f1, f2, p1;
  logic [2:0]        en, busy, done, pass;
  logic [2:0][3:0]   abcd, ff;
  logic [2:0][15:0]  tt;
  logic [2:0][4:0]   fc;
  int                mode [3];
  int                n_checks = 0;
  int                n_pass   = 0;

  always #5 clk = ~clk;

  // F = B~C + ACD + ABC (minterms 4,5,11,12,13,14,15)
  function automatic logic som(input logic [3:0] v);
    return (v[2] & ~v[1]) | (v[3] & v[1] & v[0]) | (v[3] & v[2] & v[1]);
  endfunction

  // mode 0: good evaluator, 1: F stuck-at-0, 2: F inverted at vector 11
  function automatic logic model(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b0;
      2:       return som(v) ^ (v == 4'd11);
      default: return som(v);
    endcase
  endfunction

  always_comb begin
    f0 = model(mode[0], abcd[0]);
    f1 = model(mode[1], abcd[1]);
  end

  // two-cycle-latency evaluator for the long-settle instance
  always_ff @(posedge clk) begin
    p1 <= model(mode[2], abcd[2]);
    f2 <= p1;
  end

  dec_tree_sweep_ctrl #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected_mask(mask_s), .eval_f(f0),
    .eval_en(en[0]), .eval_abcd(abcd[0]), .busy(busy[0]), .done(done[0]),
    .truth_table(tt[0]), .pass(pass[0]), .fail_cnt(fc[0]), .first_fail(ff[0]));

  dec_tree_sweep_ctrl #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected_mask(mask_s), .eval_f(f1),
    .eval_en(en[1]), .eval_abcd(abcd[1]), .busy(busy[1]), .done(done[1]),
    .truth_table(tt[1]), .pass(pass[1]), .fail_cnt(fc[1]), .first_fail(ff[1]));

  dec_tree_sweep_ctrl #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .expected_mask(mask_s), .eval_f(f2),
    .eval_en(en[2]), .eval_abcd(abcd[2]), .busy(busy[2]), .done(done[2]),
    .truth_table(tt[2]), .pass(pass[2]), .fail_cnt(fc[2]), .first_fail(ff[2]));

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  // Counts busy cycles until done, bounded; returns on the negedge of the done cycle.
  task automatic wait_done(input int i, output int bc, output bit got);
    bc = 0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (done[i]) got = 1'b1;
      else begin
        if (busy[i]) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if ({en, busy, done, pass} !== 12'h0) $display("FAIL reset_ctrl: got %h expected 000", {en, busy, done, pass}); else n_pass++;
    n_checks++; if (tt !== '0) $display("FAIL reset_table: got %h expected 0", tt); else n_pass++;
    n_checks++; if ({abcd, ff, fc} !== '0) $display("FAIL reset_idx_score: got %h expected 0", {abcd, ff, fc}); else n_pass++;
  endtask

  task automatic test_som_sweep();
    int bc; bit got;
    mode[0] = 0; mask_s = 16'hF830;
    pulse_start(0);
    wait_done(0, bc, got);
    n_checks++; if (got !== 1'b1) $display("FAIL som_done: got %0b expected 1", got); else n_pass++;
    n_checks++; if (bc != 32) $display("FAIL som_busy_cycles: got %0d expected 32", bc); else n_pass++;
    n_checks++; if (tt[0] !== 16'hF830) $display("FAIL som_table: got %h expected f830", tt[0]); else n_pass++;
    n_checks++; if ({pass[0], fc[0], ff[0]} !== {1'b1, 5'd0, 4'd0}) $display("FAIL som_score: got pass=%b cnt=%0d first=%0d expected 1/0/0", pass[0], fc[0], ff[0]); else n_pass++;
    n_checks++; if ({en[0], busy[0], abcd[0]} !== 6'b0) $display("FAIL som_done_outputs: got %b expected 000000", {en[0], busy[0], abcd[0]}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({done[0], pass[0]} !== 2'b01) $display("FAIL som_done_width: got done=%b pass=%b expected 0/1", done[0], pass[0]); else n_pass++;
  endtask

  task automatic test_stuck_at_zero();
    int bc; bit got;
    mode[0] = 1; mask_s = 16'hF830;
    pulse_start(0);
    wait_done(0, bc, got);
    n_checks++; if (got !== 1'b1 || bc != 32) $display("FAIL sa0_sweep: got done=%0b busy=%0d expected 1/32", got, bc); else n_pass++;
    n_checks++; if (tt[0] !== 16'h0000) $display("FAIL sa0_table: got %h expected 0000", tt[0]); else n_pass++;
    n_checks++; if ({pass[0], fc[0], ff[0]} !== {1'b0, 5'd7, 4'd4}) $display("FAIL sa0_score: got pass=%b cnt=%0d first=%0d expected 0/7/4", pass[0], fc[0], ff[0]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stop_on_fail();
    int bc; bit got;
    mode[1] = 2; mask_s = 16'hF830;
    pulse_start(1);
    wait_done(1, bc, got);
    n_checks++; if (got !== 1'b1 || bc != 24) $display("FAIL sof_sweep: got done=%0b busy=%0d expected 1/24", got, bc); else n_pass++;
    n_checks++; if (tt[1] !== 16'h0030) $display("FAIL sof_table: got %h expected 0030", tt[1]); else n_pass++;
    n_checks++; if ({pass[1], fc[1], ff[1]} !== {1'b0, 5'd1, 4'd11}) $display("FAIL sof_score: got pass=%b cnt=%0d first=%0d expected 0/1/11", pass[1], fc[1], ff[1]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int k = 0, errs = 0, extra = 0;
    bit got = 1'b0;
    mode[0] = 0; mask_s = 16'hF830;
    pulse_start(0);
    for (int c = 0; c < 300; c++) begin
      if (done[0]) begin got = 1'b1; break; end
      if (busy[0]) begin
        if (abcd[0] !== 4'(k / 2)) errs++;
        k++;
      end
      start_s[0] = (k == 5 || k == 20);
      if (k == 10) mask_s = 16'h0000;
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    n_checks++; if (got !== 1'b1 || k != 32) $display("FAIL ign_sweep: got done=%0b busy=%0d expected 1/32", got, k); else n_pass++;
    n_checks++; if (errs != 0) $display("FAIL ign_abcd_seq: got %0d bad cycles expected 0", errs); else n_pass++;
    n_checks++; if (pass[0] !== 1'b1) $display("FAIL ign_mask_latched: got pass=%b expected 1", pass[0]); else n_pass++;
    pulse_start(0);
    for (int c = 0; c < 6; c++) begin
      if (busy[0] || done[0]) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra != 0) $display("FAIL ign_done_start: got %0d busy/done cycles expected 0", extra); else n_pass++;
  endtask

  task automatic test_async_reset();
    int bc, dn = 0; bit got, hit = 1'b0;
    mode[0] = 0; mask_s = 16'hF830;
    pulse_start(0);
    for (int c = 0; c < 100 && !hit; c++) begin
      if (abcd[0] == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (hit !== 1'b1) $display("FAIL rst_reach_v7: got %0b expected 1", hit); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({en[0], busy[0], done[0], pass[0], abcd[0], tt[0], fc[0], ff[0]} !== '0)
      $display("FAIL rst_async_clear: got en=%b busy=%b abcd=%0d table=%h cnt=%0d expected all 0", en[0], busy[0], abcd[0], tt[0], fc[0]);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done[0] || busy[0]) dn++;
    end
    n_checks++; if (dn != 0) $display("FAIL rst_no_done: got %0d done/busy cycles expected 0", dn); else n_pass++;
    pulse_start(0);
    wait_done(0, bc, got);
    n_checks++; if (got !== 1'b1 || bc != 32 || tt[0] !== 16'hF830 || pass[0] !== 1'b1)
      $display("FAIL rst_resweep: got done=%0b busy=%0d table=%h pass=%b expected 1/32/f830/1", got, bc, tt[0], pass[0]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_settle3();
    int bc; bit got;
    mode[2] = 0; mask_s = 16'hF830;
    pulse_start(2);
    wait_done(2, bc, got);
    n_checks++; if (got !== 1'b1 || bc != 64) $display("FAIL s3_sweep: got done=%0b busy=%0d expected 1/64", got, bc); else n_pass++;
    n_checks++; if (tt[2] !== 16'hF830 || pass[2] !== 1'b1 || fc[2] !== 5'd0)
      $display("FAIL s3_result: got table=%h pass=%b cnt=%0d expected f830/1/0", tt[2], pass[2], fc[2]);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_s = '0;
    mask_s  = '0;
    for (int i = 0; i < 3; i++) mode[i] = 0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_som_sweep();
    test_stuck_at_zero();
    test_stop_on_fail();
    test_start_ignored();
    test_async_reset();
    test_settle3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
